// File: rtl/axis_sweep_pkg.sv
// Shared state encoding and default widths for the AXI-Stream sweep step generator.
package axis_sweep_pkg;

    localparam int ACC_WIDTH_DEF   = 32;
    localparam int DWELL_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/axis_sweep_dwell_cnt.sv
// Dwell beat counter: flags the accepted beat that completes the programmed dwell at one step value.
module axis_sweep_dwell_cnt
    import axis_sweep_pkg::*;
#(
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   clear,
    input  logic                   beat,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic                   expired
);

    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [DWELL_WIDTH-1:0] cnt_d;
    logic [DWELL_WIDTH-1:0] last_s;

    // A programmed dwell of zero behaves exactly like a dwell of one.
    assign last_s  = (dwell == '0) ? '0 : (dwell - DWELL_WIDTH'(1));
    assign expired = beat & ~clear & (cnt_q == last_s);

    // Next count: restart on clear or on the completing beat, advance on every other beat.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (expired) begin
            cnt_d = '0;
        end else if (beat) begin
            cnt_d = cnt_q + DWELL_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge aclk) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_sweep_step.sv
// AXI-Stream sweep step generator: walks an NCO phase-step word from start to stop in delta steps.
// Build option SWEEP_PINGPONG_EN turns the single-shot sawtooth into a continuous up/down triangle.
module axis_sweep_step
    import axis_sweep_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic [ACC_WIDTH-1:0]   cfg_start,
    input  logic [ACC_WIDTH-1:0]   cfg_stop,
    input  logic [ACC_WIDTH-1:0]   cfg_delta,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_tvalid,
    output logic                   cfg_tready,
    input  logic                   start,
    input  logic                   abort,
    output logic [ACC_WIDTH-1:0]   m_axis_data_tdata,
    output logic                   m_axis_data_tvalid,
    input  logic                   m_axis_data_tready,
    output logic                   busy,
    output logic                   done
);

    sweep_state_e           state_q;
    logic [ACC_WIDTH-1:0]   tdata_q;
    logic                   tvalid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   degen_q;
    logic [ACC_WIDTH-1:0]   start_q;
    logic [ACC_WIDTH-1:0]   stop_q;
    logic [ACC_WIDTH-1:0]   delta_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   cfg_seen_q;

    logic                   cfg_hs_s;
    logic                   launch_s;
    logic                   beat_s;
    logic                   clear_s;
    logic                   expired_s;
    logic                   degen_s;
    logic [ACC_WIDTH-1:0]   eff_start_s;
    logic [ACC_WIDTH-1:0]   eff_stop_s;
    logic [ACC_WIDTH-1:0]   eff_delta_s;
    logic [ACC_WIDTH:0]     sum_s;
    logic [ACC_WIDTH-1:0]   up_val_s;

    // Config is only writable outside a sweep, and never while reset is held.
    assign cfg_tready = ~arst & (state_q != S_SWEEP);
    assign cfg_hs_s   = cfg_tvalid & cfg_tready;

    // A launch coinciding with a config handshake uses the incoming config.
    assign eff_start_s = cfg_hs_s ? cfg_start : start_q;
    assign eff_stop_s  = cfg_hs_s ? cfg_stop  : stop_q;
    assign eff_delta_s = cfg_hs_s ? cfg_delta : delta_q;
    assign degen_s     = (eff_delta_s == '0) | (eff_start_s >= eff_stop_s);

    assign launch_s = start & ~abort & (state_q != S_SWEEP) & (cfg_hs_s | cfg_seen_q);
    assign beat_s   = (state_q == S_SWEEP) & tvalid_q & m_axis_data_tready;
    assign clear_s  = abort | (state_q != S_SWEEP);

    // Upward step computed one bit wider so a carry out also clamps to stop.
    assign sum_s    = {1'b0, tdata_q} + {1'b0, delta_q};
    assign up_val_s = (sum_s[ACC_WIDTH] | (sum_s[ACC_WIDTH-1:0] > stop_q)) ? stop_q
                                                                            : sum_s[ACC_WIDTH-1:0];

`ifdef SWEEP_PINGPONG_EN
    logic                 dir_up_q;
    logic [ACC_WIDTH:0]   diff_s;
    logic [ACC_WIDTH-1:0] dn_val_s;

    // Downward step clamps at start on either a borrow or an undershoot.
    assign diff_s   = {1'b0, tdata_q} - {1'b0, delta_q};
    assign dn_val_s = (diff_s[ACC_WIDTH] | (diff_s[ACC_WIDTH-1:0] < start_q)) ? start_q
                                                                               : diff_s[ACC_WIDTH-1:0];
`endif

    axis_sweep_dwell_cnt #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_cnt (
        .aclk   (aclk),
        .arst   (arst),
        .clear  (clear_s),
        .beat   (beat_s),
        .dwell  (dwell_q),
        .expired(expired_s)
    );

    // Sweep FSM with config capture and registered stream/status outputs.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q    <= S_IDLE;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            degen_q    <= 1'b0;
            start_q    <= '0;
            stop_q     <= '0;
            delta_q    <= '0;
            dwell_q    <= '0;
            cfg_seen_q <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            dir_up_q   <= 1'b1;
`endif
        end else begin
            if (cfg_hs_s) begin
                start_q    <= cfg_start;
                stop_q     <= cfg_stop;
                delta_q    <= cfg_delta;
                dwell_q    <= cfg_dwell;
                cfg_seen_q <= 1'b1;
            end
            if (abort) begin
                state_q  <= S_IDLE;
                tdata_q  <= '0;
                tvalid_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (launch_s) begin
                            state_q  <= S_SWEEP;
                            tdata_q  <= eff_start_s;
                            tvalid_q <= 1'b1;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            degen_q  <= degen_s;
`ifdef SWEEP_PINGPONG_EN
                            dir_up_q <= 1'b1;
`endif
                        end
                    end
                    S_SWEEP: begin
                        if (expired_s) begin
`ifdef SWEEP_PINGPONG_EN
                            // A degenerate range simply keeps presenting start.
                            if (!degen_q) begin
                                if (dir_up_q) begin
                                    if (tdata_q == stop_q) begin
                                        dir_up_q <= 1'b0;
                                        tdata_q  <= dn_val_s;
                                    end else begin
                                        tdata_q  <= up_val_s;
                                    end
                                end else begin
                                    if (tdata_q == start_q) begin
                                        dir_up_q <= 1'b1;
                                        tdata_q  <= up_val_s;
                                    end else begin
                                        tdata_q  <= dn_val_s;
                                    end
                                end
                            end
`else
                            if (degen_q || (tdata_q == stop_q)) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                tdata_q <= up_val_s;
                            end
`endif
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        tdata_q  <= '0;
                        tvalid_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
